// File: rtl/adc16dv160_input_capture_pkg.sv
// Shared types and constants for the ADC16DV160 input capture path.
package adc16dv160_input_common;

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_RUN,
    CAP_FLUSH
  } capture_state_t;

  localparam logic [15:0] TEST_PATTERN_INIT = 16'h0000;

  // FIFO entry is {last, data}
  localparam int unsigned CAP_FIFO_WIDTH = 17;

endpackage

// File: rtl/adc16dv160_input_fifo.sv
// Synchronous first-word fall-through FIFO. Read data comes straight from the
// flop array at the read pointer, so a write is visible the cycle after it lands.
module adc16dv160_input_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 17
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [Aw:0]      wptr_q, wptr_d;
  logic [Aw:0]      rptr_q, rptr_d;
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic             rd_ok;
  logic             wr_ok;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign rd_data_o = mem_q[rptr_q[Aw-1:0]];

  // A read frees a slot in the same cycle, so a full FIFO still accepts a write
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  // Next-state for pointers and storage
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_ok) begin
      mem_d[wptr_q[Aw-1:0]] = wr_data_i;
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  // Storage is reset too so the output reads zero straight out of reset
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/adc16dv160_input_capture.sv
// Collects dsize samples (ADC or test counter) into one AXI-Stream packet.
module adc16dv160_input_capture
  import adc16dv160_input_common::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  input  logic        cr_test,
  input  logic [31:0] dsize,
  input  logic [15:0] adc_data,
  input  logic        adc_valid,
  output logic [15:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY,
  output logic        sr_pc,
  output logic        sr_ovf
);

  capture_state_t state_q, state_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [15:0]    pat_q, pat_d;
  logic           test_q, test_d;
  logic           pc_q, pc_d;
  logic           ovf_q, ovf_d;

  logic                      fifo_wr;
  logic [CAP_FIFO_WIDTH-1:0] fifo_wdata;
  logic [CAP_FIFO_WIDTH-1:0] fifo_rdata;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      fifo_rd;
  logic                      can_wr;
  logic                      avail;

  assign M_AXIS_TVALID = !fifo_empty;
  assign M_AXIS_TDATA  = fifo_rdata[15:0];
  assign M_AXIS_TLAST  = fifo_rdata[16];
  assign sr_pc         = pc_q;
  assign sr_ovf        = ovf_q;

  assign fifo_rd = M_AXIS_TVALID && M_AXIS_TREADY;
  // Full is judged after this cycle's read
  assign can_wr  = !fifo_full || fifo_rd;
  assign avail   = test_q || adc_valid;

  // Capture FSM next-state, counters and status flags
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    test_d     = test_q;
    pc_d       = pc_q;
    ovf_d      = ovf_q;
    fifo_wr    = 1'b0;
    fifo_wdata = {(cnt_q == 32'd1), (test_q ? pat_q : adc_data)};
    unique case (state_q)
      CAP_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (dsize != 32'd0) begin
            state_d = CAP_RUN;
            cnt_d   = dsize;
            test_d  = cr_test;
            pat_d   = TEST_PATTERN_INIT;
            pc_d    = 1'b0;
          end else begin
            pc_d = 1'b1;
          end
        end
      end
      CAP_RUN: begin
        if (avail) begin
          if (can_wr) begin
            fifo_wr = 1'b1;
            cnt_d   = cnt_q - 32'd1;
            if (test_q) begin
              pat_d = pat_q + 16'd1;
            end
            if (cnt_q == 32'd1) begin
              state_d = CAP_FLUSH;
            end
          end else if (!test_q) begin
            // ADC cannot be stalled: the sample is lost
            ovf_d = 1'b1;
          end
        end
      end
      CAP_FLUSH: begin
        if (fifo_rd && M_AXIS_TLAST) begin
          pc_d    = 1'b1;
          state_d = CAP_IDLE;
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  // Capture state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= CAP_IDLE;
      cnt_q   <= '0;
      pat_q   <= TEST_PATTERN_INIT;
      test_q  <= 1'b0;
      pc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      test_q  <= test_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
    end
  end

  adc16dv160_input_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CAP_FIFO_WIDTH)
  ) u_fifo (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .wr_en_i   (fifo_wr),
    .wr_data_i (fifo_wdata),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

endmodule

// File: tb/tb_adc16dv160_input_capture.sv
// Scoreboard bench for the ADC16DV160 input capture stage.
module tb_adc16dv160_input_capture;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        start;
  logic        cr_test;
  logic [31:0] dsize;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic [15:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TREADY;
  logic        sr_pc;
  logic        sr_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  logic [16:0] exp_q [$];
  logic        pend_pc;
  logic        hold_v;
  logic [16:0] hold_beat;

  adc16dv160_input_capture #(
    .FIFO_DEPTH (16)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .start         (start),
    .cr_test       (cr_test),
    .dsize         (dsize),
    .adc_data      (adc_data),
    .adc_valid     (adc_valid),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .sr_pc         (sr_pc),
    .sr_ovf        (sr_ovf)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_start(input logic [31:0] d, input logic t);
    start   = 1'b1;
    dsize   = d;
    cr_test = t;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pc(input int budget);
    int n;
    n = 0;
    while (!sr_pc && n < budget) begin
      tick();
      n++;
    end
    check("pc_done", {31'd0, sr_pc}, 32'd1);
  endtask

  task automatic push_pattern(input int len, input int base);
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({(i == len - 1), 16'(base + i)});
    end
  endtask

  // Monitor: pops one expected beat per handshake, checks AXI hold rules and sr_pc timing
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      pend_pc <= 1'b0;
      hold_v  <= 1'b0;
    end else begin
      if (pend_pc) begin
        check("pc_after_last", {31'd0, sr_pc}, 32'd1);
        pend_pc <= 1'b0;
      end
      if (hold_v) begin
        check("tvalid_hold", {31'd0, M_AXIS_TVALID}, 32'd1);
        check("beat_hold", {15'd0, M_AXIS_TLAST, M_AXIS_TDATA}, {15'd0, hold_beat});
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %h, expected no beat", {M_AXIS_TLAST, M_AXIS_TDATA});
        end else begin
          check("beat", {15'd0, M_AXIS_TLAST, M_AXIS_TDATA}, {15'd0, exp_q.pop_front()});
        end
        if (M_AXIS_TLAST) begin
          check("pc_before_last", {31'd0, sr_pc}, 32'd0);
          pend_pc <= 1'b1;
        end
      end
      hold_v    <= M_AXIS_TVALID && !M_AXIS_TREADY;
      hold_beat <= {M_AXIS_TLAST, M_AXIS_TDATA};
    end
  end

  initial begin
    ARESETN       = 1'b0;
    start         = 1'b0;
    cr_test       = 1'b0;
    dsize         = '0;
    adc_data      = '0;
    adc_valid     = 1'b0;
    M_AXIS_TREADY = 1'b0;
    repeat (2) tick();
    check("rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    check("rst_tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
    check("rst_tdata", {16'd0, M_AXIS_TDATA}, 32'd0);
    check("rst_pc", {31'd0, sr_pc}, 32'd0);
    check("rst_ovf", {31'd0, sr_ovf}, 32'd0);
    ARESETN = 1'b1;
    tick();

    // Zero size: completes immediately with no beats
    M_AXIS_TREADY = 1'b1;
    do_start(32'd0, 1'b0);
    check("zero_pc", {31'd0, sr_pc}, 32'd1);
    check("zero_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    tick();
    check("zero_tvalid2", {31'd0, M_AXIS_TVALID}, 32'd0);

    // Test mode, no backpressure
    push_pattern(5, 0);
    do_start(32'd5, 1'b1);
    check("t1_pc_cleared", {31'd0, sr_pc}, 32'd0);
    wait_pc(50);
    check("t1_ovf", {31'd0, sr_ovf}, 32'd0);

    // ADC mode with gaps
    exp_q.push_back({1'b0, 16'hA5A5});
    exp_q.push_back({1'b0, 16'h0001});
    exp_q.push_back({1'b1, 16'hFFFF});
    do_start(32'd3, 1'b0);
    adc_valid = 1'b1; adc_data = 16'hA5A5; tick();
    adc_valid = 1'b0; adc_data = 16'h1234; tick();
    adc_valid = 1'b1; adc_data = 16'h0001; tick();
    adc_valid = 1'b0; adc_data = 16'h4321; tick(); tick();
    adc_valid = 1'b1; adc_data = 16'hFFFF; tick();
    adc_valid = 1'b1; adc_data = 16'hDEAD; tick();
    adc_valid = 1'b0;
    wait_pc(50);
    check("t2_ovf", {31'd0, sr_ovf}, 32'd0);

    // Overflow: 16 fit, 4 dropped, then drain while streaming the rest
    M_AXIS_TREADY = 1'b0;
    push_pattern(16, 16'h1000);
    for (int j = 0; j < 24; j++) begin
      exp_q.push_back({(j == 23), 16'(16'h2000 + j)});
    end
    exp_q[15] = {1'b0, 16'h100F};
    do_start(32'd40, 1'b0);
    for (int i = 0; i < 20; i++) begin
      adc_valid = 1'b1;
      adc_data  = 16'(16'h1000 + i);
      tick();
      if (i == 15) check("ovf_before", {31'd0, sr_ovf}, 32'd0);
      if (i == 16) check("ovf_after", {31'd0, sr_ovf}, 32'd1);
    end
    M_AXIS_TREADY = 1'b1;
    for (int j = 0; j < 24; j++) begin
      adc_valid = 1'b1;
      adc_data  = 16'(16'h2000 + j);
      tick();
    end
    adc_valid = 1'b0;
    wait_pc(100);
    check("ovf_sticky", {31'd0, sr_ovf}, 32'd1);

    // Test-mode backpressure: pattern throttled, never dropped
    M_AXIS_TREADY = 1'b0;
    push_pattern(20, 0);
    do_start(32'd20, 1'b1);
    check("t4_ovf_cleared", {31'd0, sr_ovf}, 32'd0);
    for (int i = 0; i < 200 && !sr_pc; i++) begin
      M_AXIS_TREADY = ~M_AXIS_TREADY;
      tick();
    end
    check("t4_pc", {31'd0, sr_pc}, 32'd1);
    check("t4_ovf", {31'd0, sr_ovf}, 32'd0);
    M_AXIS_TREADY = 1'b1;

    // Start during RUN is ignored
    push_pattern(6, 0);
    do_start(32'd6, 1'b1);
    tick();
    start = 1'b1; dsize = 32'd2; tick();
    start = 1'b0;
    wait_pc(50);

    // Reset mid-packet aborts, next packet restarts the pattern
    M_AXIS_TREADY = 1'b0;
    do_start(32'd30, 1'b1);
    repeat (5) tick();
    ARESETN = 1'b0;
    #1;
    exp_q.delete();
    check("abort_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
    check("abort_tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
    check("abort_tdata", {16'd0, M_AXIS_TDATA}, 32'd0);
    check("abort_pc", {31'd0, sr_pc}, 32'd0);
    check("abort_ovf", {31'd0, sr_ovf}, 32'd0);
    tick();
    ARESETN       = 1'b1;
    M_AXIS_TREADY = 1'b1;
    tick();
    push_pattern(3, 0);
    do_start(32'd3, 1'b1);
    wait_pc(50);

    tick();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc16dv160_input_capture.md
# adc16dv160_input_capture

Capture stage that sits between the ADC16DV160 sample interface and the AXI-Lite register block. On a start pulse it collects exactly `dsize` 16-bit samples and emits them as one AXI-Stream packet with TLAST on the final beat. Samples come either from the ADC or, in test mode, from an internal incrementing counter. It produces the packet-complete status `sr_pc` and the sticky overflow status `sr_ovf`, both readable through the register block.

## Interface
- `FIFO_DEPTH`, 16: output buffer depth in samples; must be a power of two, ≥ 2.
- `ACLK` in 1: single clock. The ADC data is already in this domain.
- `ARESETN` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse from the CR start bit.
- `cr_test` in 1: test-pattern select; sampled only on an accepted `start`.
- `dsize` in 32: samples per packet; sampled only on an accepted `start`.
- `adc_data` in 16: ADC sample.
- `adc_valid` in 1: `adc_data` is valid this cycle. The ADC cannot be stalled.
- `M_AXIS_TDATA` out 16: sample.
- `M_AXIS_TVALID` out 1: beat valid.
- `M_AXIS_TLAST` out 1: final beat of the packet.
- `M_AXIS_TREADY` in 1: downstream ready.
- `sr_pc` out 1: packet complete. Level signal; cleared by the next accepted `start`.
- `sr_ovf` out 1: sticky flag, set when an ADC sample is dropped; cleared by the next accepted `start`.

## Operation
- Reset values:
  - state IDLE
  - `sr_pc`=0, `sr_ovf`=0
  - `M_AXIS_TVALID`=0, `M_AXIS_TLAST`=0, `M_AXIS_TDATA`=0
  - FIFO empty; remaining-sample counter 0; pattern counter 0
- State IDLE:
  - `start` with `dsize`≠0: latch `dsize` into a 32-bit down-counter, latch `cr_test`, clear `sr_pc` and `sr_ovf`, reset the pattern counter to 16'h0000, go to RUN.
  - `start` with `dsize`=0: clear `sr_ovf`, set `sr_pc` on the next edge, stay in IDLE. No beats are emitted.
- State RUN:
  - A write occurs when a sample is available and the FIFO is not full.
  - ADC mode: a sample is available when `adc_valid`=1. If the FIFO is full, the sample is dropped, `sr_ovf` is set, and the counter is unchanged.
  - Test mode: a sample is available every cycle. It is written only when the FIFO is not full, so backpressure throttles the pattern and nothing is ever dropped. The pattern counter increments on each write and wraps 16'hFFFF→16'h0000.
  - Each write stores {last, data}, with last=1 when the counter equals 1, then decrements the counter.
  - After the write with last=1, go to FLUSH. Samples arriving after that write are ignored and do not set `sr_ovf`.
- State FLUSH: wait for the handshake of the beat with TLAST=1, then set `sr_pc` and go to IDLE.
- A `start` in RUN or FLUSH is ignored.
- Reset mid-packet aborts immediately. The FIFO is emptied and no TLAST is emitted.

## Timing
- A write at edge N makes the beat visible on `M_AXIS_*` after edge N (FIFO output is registered, first-word fall-through). Latency is 1 cycle when the FIFO is empty.
- AXI-Stream rules:
  - Handshake is `TVALID`&&`TREADY` at a rising edge.
  - `TDATA` and `TLAST` stay stable while `TVALID`=1 and `TREADY`=0.
  - `TVALID` does not depend combinationally on `TREADY`.
- Simultaneous read and write when full: the write is accepted. Full is evaluated after the read, so a full FIFO with `TREADY`=1 does not drop a sample.
- `sr_pc` rises on the edge after the final handshake (1 cycle later) and stays high until the next accepted `start`.
- `sr_ovf` rises on the edge of the dropped sample.
- Widths:
  - The counter is 32 bits, so `dsize` up to 2^32−1 is legal.
  - FIFO pointers are log2(FIFO_DEPTH)+1 bits wide, giving a full/empty distinction.

## Structure
- Shared package `adc16dv160_input_common` gains:
  - `capture_state_t` enum {CAP_IDLE, CAP_RUN, CAP_FLUSH}
  - `TEST_PATTERN_INIT` = 16'h0000
- Sub-module `adc16dv160_input_fifo`: synchronous, 17 bits wide, depth `FIFO_DEPTH`, first-word fall-through, with asynchronous active-low reset on `ARESETN`.

## Test plan
- **Test mode, no backpressure:** `cr_test`=1, `dsize`=5, `TREADY`=1 → TDATA 0,1,2,3,4; TLAST only on data 4; `sr_pc`=1 one cycle after the last handshake.
- **ADC mode with gaps:** `dsize`=3; `adc_valid` pulses carrying A5A5, 0001, FFFF → the same 3 beats, TLAST on FFFF; `sr_ovf`=0.
- **Overflow:** ADC mode, `dsize`=40, `TREADY`=0, `adc_valid`=1 for 20 cycles → `sr_ovf`=1 after the 17th sample. Releasing `TREADY` yields the first 16 samples in order.
- **Test-mode backpressure:** `dsize`=20, `TREADY` toggling → 20 contiguous values 0..19; no drops; `sr_ovf`=0.
- **Zero size:** `start` with `dsize`=0 → no TVALID; `sr_pc`=1 on the next cycle.
- **Reset and ignored start:**
  - `start` pulsed during RUN → ignored; the packet length is unchanged.
  - `ARESETN` low mid-packet → all outputs return to reset values.
  - A new packet afterwards restarts at pattern 0.
